// File: rtl/hazard_scoreboard.sv
// Scoreboard of in-flight register writes with per-op-class latency.
// Drives fetch/decode stall, E bubble, D flush and the E-stage forwarding selects.
module hazard_scoreboard #(
  parameter int AW       = 5,
  parameter int CW       = 3,
  parameter int LOAD_LAT = 1,
  parameter int MUL_LAT  = 4,
  parameter int ALU_LAT  = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          freeze,
  input  logic          issue_valid_d,
  input  logic [AW-1:0] rs1_d,
  input  logic [AW-1:0] rs2_d,
  input  logic          use_rs1_d,
  input  logic          use_rs2_d,
  input  logic [AW-1:0] rd_d,
  input  logic          we_d,
  input  logic          load_d,
  input  logic          mul_d,
  input  logic          redirect_m,
  input  logic [AW-1:0] rs1_e,
  input  logic [AW-1:0] rs2_e,
  input  logic [AW-1:0] rd_m,
  input  logic          we_m,
  input  logic [AW-1:0] rd_w,
  input  logic          we_w,
  output logic          stall_fd,
  output logic          bubble_e,
  output logic          flush_d,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b,
  output logic          issued
);

  localparam int NREG = 2 ** AW;
  localparam logic [CW-1:0] LOAD_CNT = CW'(LOAD_LAT);
  localparam logic [CW-1:0] MUL_CNT  = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] ALU_CNT  = CW'(ALU_LAT);

  logic [CW-1:0] r_cnt [NREG];
  logic [NREG-1:0] r_pend;
  logic [AW-1:0] r_e_rd;
  logic r_e_alloc;

  logic w_haz_rs1;
  logic w_haz_rs2;
  logic w_haz_waw;
  logic w_stall;
  logic w_alloc;
  logic [CW-1:0] w_lat;

  // A pending entry whose counter has reached 0 is already forwardable, so it no longer blocks.
  assign w_haz_rs1 = use_rs1_d && (rs1_d != '0) && r_pend[rs1_d] && (r_cnt[rs1_d] != '0);
  assign w_haz_rs2 = use_rs2_d && (rs2_d != '0) && r_pend[rs2_d] && (r_cnt[rs2_d] != '0);
  assign w_haz_waw = we_d && (rd_d != '0) && r_pend[rd_d] && (r_cnt[rd_d] != '0);

  assign w_stall  = issue_valid_d && (w_haz_rs1 || w_haz_rs2 || w_haz_waw) && !redirect_m;
  assign issued   = issue_valid_d && !w_stall && !redirect_m && !freeze;
  assign stall_fd = w_stall;
  assign bubble_e = w_stall || redirect_m;
  assign flush_d  = redirect_m;

  assign w_alloc = issued && we_d && (rd_d != '0);
  assign w_lat   = load_d ? LOAD_CNT : (mul_d ? MUL_CNT : ALU_CNT);

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (we_m && (rd_m == rs1_e) && (rs1_e != '0)) fwd_a = 2'b01;
    else if (we_w && (rd_w == rs1_e) && (rs1_e != '0)) fwd_a = 2'b10;
    if (we_m && (rd_m == rs2_e) && (rs2_e != '0)) fwd_b = 2'b01;
    else if (we_w && (rd_w == rs2_e) && (rs2_e != '0)) fwd_b = 2'b10;
  end

  // Later assignments win: squash of the E-stage allocation overrides aging, new allocation overrides both.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) r_cnt[i] <= '0;
      r_pend    <= '0;
      r_e_rd    <= '0;
      r_e_alloc <= 1'b0;
    end else if (!freeze) begin
      for (int i = 0; i < NREG; i++) begin
        if (r_cnt[i] != '0) r_cnt[i] <= r_cnt[i] - 1'b1;
        else r_pend[i] <= 1'b0;
      end
      if (redirect_m && r_e_alloc) begin
        r_pend[r_e_rd] <= 1'b0;
        r_cnt[r_e_rd]  <= '0;
      end
      if (w_alloc) begin
        r_pend[rd_d] <= 1'b1;
        r_cnt[rd_d]  <= w_lat;
      end
      r_e_rd    <= rd_d;
      r_e_alloc <= w_alloc;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed pipeline scenarios plus
// randomized traffic compared against a timestamp-based reference model.
module tb_hazard_scoreboard;

  localparam int AW = 5;

  logic clk = 1'b0;
  logic reset, freeze, issue_valid_d;
  logic [AW-1:0] rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_m, rd_w;
  logic use_rs1_d, use_rs2_d, we_d, load_d, mul_d, redirect_m, we_m, we_w;
  logic stall_fd, bubble_e, flush_d, issued;
  logic [1:0] fwd_a, fwd_b;

  int checks = 0;
  int errors = 0;

  // Reference model: each register remembers the active cycle at which its value becomes forwardable.
  int readyAt [32];
  int activeCycle = 0;
  int eRd = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.AW(AW), .CW(3), .LOAD_LAT(1), .MUL_LAT(4), .ALU_LAT(0)) dut (
    .clk(clk), .reset(reset), .freeze(freeze), .issue_valid_d(issue_valid_d),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d),
    .rd_d(rd_d), .we_d(we_d), .load_d(load_d), .mul_d(mul_d), .redirect_m(redirect_m),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_m(rd_m), .we_m(we_m), .rd_w(rd_w), .we_w(we_w),
    .stall_fd(stall_fd), .bubble_e(bubble_e), .flush_d(flush_d),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .issued(issued)
  );

  function automatic bit mBusy(input logic [AW-1:0] r);
    return (r != 0) && (activeCycle < readyAt[r]);
  endfunction

  function automatic bit mStall();
    return issue_valid_d && ((use_rs1_d && mBusy(rs1_d)) || (use_rs2_d && mBusy(rs2_d)) ||
           (we_d && mBusy(rd_d))) && !redirect_m;
  endfunction

  function automatic bit mIssued();
    return issue_valid_d && !mStall() && !redirect_m && !freeze;
  endfunction

  function automatic logic [1:0] mFwd(input logic [AW-1:0] s);
    if (s == 0) return 2'b00;
    if (we_m && rd_m == s) return 2'b01;
    if (we_w && rd_w == s) return 2'b10;
    return 2'b00;
  endfunction

  function automatic int mLat();
    return load_d ? 1 : (mul_d ? 3 : 0);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) readyAt[i] <= 0;
      eRd <= 0;
    end else if (!freeze) begin
      if (redirect_m && eRd != 0) readyAt[eRd] <= 0;
      if (mIssued() && we_d && rd_d != 0) begin
        readyAt[rd_d] <= activeCycle + mLat() + 1;
        eRd <= int'(rd_d);
      end else begin
        eRd <= 0;
      end
      activeCycle <= activeCycle + 1;
    end
  end

  task automatic idle();
    issue_valid_d = 0; use_rs1_d = 0; use_rs2_d = 0; rs1_d = 0; rs2_d = 0; rd_d = 0;
    we_d = 0; load_d = 0; mul_d = 0; redirect_m = 0; freeze = 0;
    rs1_e = 0; rs2_e = 0; rd_m = 0; we_m = 0; rd_w = 0; we_w = 0;
  endtask

  task automatic stepIdle();
    @(negedge clk);
    idle();
  endtask

  task automatic setD(input int rd, input int we, input int ld, input int ml,
                      input int s1, input int u1, input int s2, input int u2);
    issue_valid_d = 1'b1;
    rd_d = AW'(rd); we_d = (we != 0); load_d = (ld != 0); mul_d = (ml != 0);
    rs1_d = AW'(s1); use_rs1_d = (u1 != 0); rs2_d = AW'(s2); use_rs2_d = (u2 != 0);
  endtask

  task automatic doReset();
    @(negedge clk);
    idle();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Presents the same D instruction each cycle until it issues (bounded), counting stall cycles.
  task automatic waitIssue(input int rd, input int we, input int ld, input int ml,
                           input int s1, input int u1, input int s2, input int u2,
                           output int stalls, output bit ok);
    stalls = 0;
    ok = 1'b0;
    for (int k = 0; k < 10 && !ok; k++) begin
      stepIdle();
      setD(rd, we, ld, ml, s1, u1, s2, u2);
      #1;
      if (issued === 1'b1) ok = 1'b1;
      else stalls++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    issue_valid_d = 1'b1; rs1_d = 3; use_rs1_d = 1'b1; rs1_e = 3; rs2_e = 4;
    #1;
    checks++; if (stall_fd !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall_fd); end
    checks++; if (bubble_e !== 1'b0) begin errors++; $display("FAIL reset_bubble: got %b want 0", bubble_e); end
    checks++; if (flush_d !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b want 0", flush_d); end
    checks++; if (issued !== 1'b1) begin errors++; $display("FAIL reset_issued: got %b want 1", issued); end
    checks++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin errors++; $display("FAIL reset_fwd: got %b/%b want 00/00", fwd_a, fwd_b); end
    freeze = 1'b1;
    #1;
    checks++; if (issued !== 1'b0) begin errors++; $display("FAIL reset_freeze_issued: got %b want 0", issued); end
  endtask

  task automatic test_alu_forward();
    doReset();
    stepIdle(); setD(5, 1, 0, 0, 1, 1, 2, 1); #1;
    checks++; if (issued !== 1'b1) begin errors++; $display("FAIL alu_issue: got %b want 1", issued); end
    stepIdle(); setD(11, 1, 0, 0, 5, 1, 3, 1); #1;
    checks++; if (stall_fd !== 1'b0) begin errors++; $display("FAIL alu_use_stall: got %b want 0", stall_fd); end
    checks++; if (issued !== 1'b1) begin errors++; $display("FAIL alu_use_issued: got %b want 1", issued); end
    stepIdle(); rs1_e = 5; rs2_e = 3; rd_m = 5; we_m = 1'b1; setD(5, 1, 1, 0, 5, 1, 0, 0); #1;
    checks++; if (fwd_a !== 2'b01) begin errors++; $display("FAIL alu_fwd_a: got %b want 01", fwd_a); end
    checks++; if (fwd_b !== 2'b00) begin errors++; $display("FAIL alu_fwd_b: got %b want 00", fwd_b); end
    checks++; if (stall_fd !== 1'b0) begin errors++; $display("FAIL alu_pend_clear: got %b want 0", stall_fd); end
  endtask

  task automatic test_load_use();
    doReset();
    stepIdle(); setD(6, 1, 1, 0, 2, 1, 0, 0); #1;
    checks++; if (issued !== 1'b1) begin errors++; $display("FAIL load_issue: got %b want 1", issued); end
    stepIdle(); setD(7, 1, 0, 0, 6, 1, 1, 1); #1;
    checks++; if (stall_fd !== 1'b1) begin errors++; $display("FAIL load_use_stall: got %b want 1", stall_fd); end
    checks++; if (bubble_e !== 1'b1) begin errors++; $display("FAIL load_use_bubble: got %b want 1", bubble_e); end
    checks++; if (issued !== 1'b0) begin errors++; $display("FAIL load_use_hold: got %b want 0", issued); end
    stepIdle(); setD(7, 1, 0, 0, 6, 1, 1, 1); #1;
    checks++; if (stall_fd !== 1'b0) begin errors++; $display("FAIL load_use_release: got %b want 0", stall_fd); end
    checks++; if (issued !== 1'b1) begin errors++; $display("FAIL load_use_issued: got %b want 1", issued); end
    stepIdle(); rs1_e = 6; rs2_e = 1; rd_w = 6; we_w = 1'b1; #1;
    checks++; if (fwd_a !== 2'b10) begin errors++; $display("FAIL load_fwd_a: got %b want 10", fwd_a); end
  endtask

  task automatic test_mul();
    int st;
    bit ok;
    doReset();
    stepIdle(); setD(8, 1, 0, 1, 1, 1, 2, 1); #1;
    checks++; if (issued !== 1'b1) begin errors++; $display("FAIL mul_issue: got %b want 1", issued); end
    waitIssue(9, 1, 0, 0, 8, 1, 0, 0, st, ok);
    checks++; if (!ok || st != 3) begin errors++; $display("FAIL mul_use_stalls: got %0d (issued=%b) want 3", st, ok); end
    doReset();
    stepIdle(); setD(8, 1, 0, 1, 1, 1, 2, 1); #1;
    waitIssue(8, 1, 0, 1, 3, 1, 4, 1, st, ok);
    checks++; if (!ok || st != 3) begin errors++; $display("FAIL mul_waw_stalls: got %0d (issued=%b) want 3", st, ok); end
  endtask

  task automatic test_squash();
    for (int pass = 0; pass < 2; pass++) begin
      doReset();
      stepIdle(); setD(9, 1, (pass == 0) ? 1 : 0, (pass == 1) ? 1 : 0, 1, 1, 0, 0); #1;
      stepIdle(); setD(10, 1, 0, 0, 9, 1, 0, 0); redirect_m = 1'b1; #1;
      checks++; if (stall_fd !== 1'b0) begin errors++; $display("FAIL squash_stall[%0d]: got %b want 0", pass, stall_fd); end
      checks++; if (flush_d !== 1'b1 || bubble_e !== 1'b1) begin errors++; $display("FAIL squash_flush_bubble[%0d]: got %b%b want 11", pass, flush_d, bubble_e); end
      checks++; if (issued !== 1'b0) begin errors++; $display("FAIL squash_issued[%0d]: got %b want 0", pass, issued); end
      stepIdle(); setD(10, 1, 0, 0, 9, 1, 0, 0); #1;
      checks++; if (stall_fd !== 1'b0 || issued !== 1'b1) begin errors++; $display("FAIL squash_after[%0d]: got stall=%b issued=%b want 0/1", pass, stall_fd, issued); end
    end
  endtask

  task automatic test_freeze();
    int st;
    bit ok;
    doReset();
    stepIdle(); setD(6, 1, 1, 0, 2, 1, 0, 0); #1;
    for (int k = 0; k < 5; k++) begin
      stepIdle(); setD(7, 1, 0, 0, 6, 1, 0, 0); freeze = 1'b1; #1;
      checks++; if (issued !== 1'b0 || stall_fd !== 1'b1) begin errors++; $display("FAIL freeze_hold[%0d]: got issued=%b stall=%b want 0/1", k, issued, stall_fd); end
    end
    waitIssue(7, 1, 0, 0, 6, 1, 0, 0, st, ok);
    checks++; if (!ok || st != 1) begin errors++; $display("FAIL freeze_release_stalls: got %0d (issued=%b) want 1", st, ok); end
  endtask

  task automatic test_forwarding();
    doReset();
    stepIdle(); setD(0, 1, 1, 0, 1, 1, 2, 1); #1;
    stepIdle(); setD(0, 1, 0, 1, 1, 1, 2, 1); #1;
    checks++; if (issued !== 1'b1) begin errors++; $display("FAIL x0_waw: got issued=%b want 1", issued); end
    stepIdle(); setD(12, 1, 0, 0, 0, 1, 0, 1); rs1_e = 0; rs2_e = 0; rd_m = 0; we_m = 1'b1; rd_w = 0; we_w = 1'b1; #1;
    checks++; if (stall_fd !== 1'b0) begin errors++; $display("FAIL x0_stall: got %b want 0", stall_fd); end
    checks++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin errors++; $display("FAIL x0_fwd: got %b/%b want 00/00", fwd_a, fwd_b); end
    rs1_e = 3; rs2_e = 4; rd_m = 3; rd_w = 3; #1;
    checks++; if (fwd_a !== 2'b01 || fwd_b !== 2'b00) begin errors++; $display("FAIL fwd_m_priority: got %b/%b want 01/00", fwd_a, fwd_b); end
    rd_w = 4; #1;
    checks++; if (fwd_b !== 2'b10) begin errors++; $display("FAIL fwd_w_only: got %b want 10", fwd_b); end
  endtask

  task automatic test_reset_mid_mul();
    doReset();
    stepIdle(); setD(8, 1, 0, 1, 1, 1, 2, 1); #1;
    stepIdle(); setD(9, 1, 0, 0, 8, 1, 0, 0); reset = 1'b1; #1;
    stepIdle(); reset = 1'b0; setD(8, 1, 0, 0, 8, 1, 0, 0); #1;
    checks++; if (stall_fd !== 1'b0 || issued !== 1'b1) begin errors++; $display("FAIL reset_mid_mul: got stall=%b issued=%b want 0/1", stall_fd, issued); end
  endtask

  task automatic test_random();
    int sel;
    doReset();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      reset = ($urandom_range(99) == 0);
      freeze = ($urandom_range(7) == 0);
      redirect_m = ($urandom_range(7) == 0);
      issue_valid_d = ($urandom_range(3) != 0);
      rs1_d = AW'($urandom_range(7)); rs2_d = AW'($urandom_range(7)); rd_d = AW'($urandom_range(7));
      use_rs1_d = $urandom_range(1) != 0; use_rs2_d = $urandom_range(1) != 0;
      we_d = ($urandom_range(4) != 0);
      sel = int'($urandom_range(2));
      load_d = (sel == 1); mul_d = (sel == 2);
      rs1_e = AW'($urandom_range(7)); rs2_e = AW'($urandom_range(7));
      rd_m = AW'($urandom_range(7)); rd_w = AW'($urandom_range(7));
      we_m = $urandom_range(1) != 0; we_w = $urandom_range(1) != 0;
      #1;
      checks++; if (stall_fd !== mStall()) begin errors++; $display("FAIL rnd_stall @%0d: got %b want %b", n, stall_fd, mStall()); end
      checks++; if (bubble_e !== (mStall() || redirect_m)) begin errors++; $display("FAIL rnd_bubble @%0d: got %b want %b", n, bubble_e, mStall() || redirect_m); end
      checks++; if (flush_d !== redirect_m) begin errors++; $display("FAIL rnd_flush @%0d: got %b want %b", n, flush_d, redirect_m); end
      checks++; if (issued !== mIssued()) begin errors++; $display("FAIL rnd_issued @%0d: got %b want %b", n, issued, mIssued()); end
      checks++; if (fwd_a !== mFwd(rs1_e)) begin errors++; $display("FAIL rnd_fwd_a @%0d: got %b want %b", n, fwd_a, mFwd(rs1_e)); end
      checks++; if (fwd_b !== mFwd(rs2_e)) begin errors++; $display("FAIL rnd_fwd_b @%0d: got %b want %b", n, fwd_b, mFwd(rs2_e)); end
    end
    reset = 1'b0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    test_reset();
    test_alu_forward();
    test_load_use();
    test_mul();
    test_squash();
    test_freeze();
    test_forwarding();
    test_reset_mid_mul();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard and forwarding controller for the pipelined datapath. It keeps a per-register scoreboard of pending writes with per-op-class latency: ALU, load and pipelined multiply. It generates fetch/decode stall, E-stage bubble and D-stage flush. It also produces the E-stage operand forwarding selects. It replaces the stateless forward unit and the `alu_busy` whole-pipe freeze for multiply.

## Interface
Parameters:
- `AW`, 5, register address width; scoreboard has 2**AW entries; entry 0 never allocated
- `CW`, 3, latency counter width
- `LOAD_LAT`, 1, counter value loaded for a load destination
- `MUL_LAT`, 4, multiplier pipeline depth; counter loaded with MUL_LAT-1; must be ≤ 2**CW
- `ALU_LAT`, 0, counter value loaded for an ALU destination

Ports:
- `clk`  in  1  clock, rising edge
- `reset`  in  1  synchronous, active-high; clears all state
- `freeze`  in  1  external hold, driven as ~dhit; state holds, no issue
- `issue_valid_d`  in  1  D holds a valid instruction
- `rs1_d`, `rs2_d`  in  AW  D source registers
- `use_rs1_d`, `use_rs2_d`  in  1  source actually read
- `rd_d`  in  AW  D destination
- `we_d`  in  1  D writes the register file
- `load_d`, `mul_d`  in  1  op class of D (both 0 = ALU; both 1 illegal)
- `redirect_m`  in  1  taken branch or jump resolved in M
- `rs1_e`, `rs2_e`  in  AW  E source registers
- `rd_m`, `we_m`  in  AW/1  M-stage destination
- `rd_w`, `we_w`  in  AW/1  W-stage destination
- `stall_fd`  out  1  hold PC and D register
- `bubble_e`  out  1  load NOP into E register
- `flush_d`  out  1  squash D register
- `fwd_a`, `fwd_b`  out  2  00 = register file, 01 = ALUOutM, 10 = ResultW, 11 unused
- `issued`  out  1  D instruction enters E this cycle

## Operation
- Scoreboard: `cnt[r]` (CW bits) and `pend[r]` per register. `pend` = 1 means a write to r is in flight. `cnt` = cycles until the value is forwardable to E.
- Source hazard when a used source s ≠ 0 has `pend[s]` and `cnt[s]` ≠ 0.
- WAW hazard when `we_d`, `rd_d` ≠ 0 and `pend[rd_d]` = 1 with `cnt[rd_d]` ≠ 0.
- `stall` = issue_valid_d & (source hazard | WAW hazard) & ~redirect_m.
- `issued` = issue_valid_d & ~stall & ~redirect_m & ~freeze.
- Outputs (combinational): `stall_fd` = stall; `bubble_e` = stall | redirect_m; `flush_d` = redirect_m.
- Freeze takes priority over all state updates. When freeze = 1, stall_fd/bubble_e/flush_d still evaluate normally; the pipeline registers ignore them.
- Forwarding, per operand x ∈ {a, b} with source s = rs1_e/rs2_e:
  - 01 if we_m & rd_m == s & s ≠ 0
  - else 10 if we_w & rd_w == s & s ≠ 0
  - else 00
  - M has priority over W.
- E tracker: `e_rd`, `e_alloc` record the allocation made by the instruction currently in E. They are loaded on every non-frozen edge: with (rd_d, 1) if issued & we_d & rd_d ≠ 0, else (x, 0).
- Clock update when not reset and not freeze, applied in order:
  1. every `cnt` ≠ 0 decrements by 1; a `pend` entry with `cnt` = 0 clears.
  2. if redirect_m & e_alloc: `pend[e_rd]` ← 0 and `cnt[e_rd]` ← 0. Squash overrides decrement.
  3. if issued & we_d & rd_d ≠ 0: `pend[rd_d]` ← 1 and `cnt[rd_d]` ← the latency for the op class (LOAD_LAT, MUL_LAT-1 or ALU_LAT).
- `cnt` saturates at 0 and never wraps. Register 0 is never allocated and never forwarded.

## Timing
- Reset values: all `cnt`/`pend`/`e_alloc` = 0. Outputs stall_fd = 0, bubble_e = 0, flush_d = 0, issued = issue_valid_d & ~redirect_m & ~freeze, fwd_a = fwd_b = 00 when we_m = we_w = 0.
- Reset mid-operation discards all pending entries. A squashed or in-flight multiply leaves no residue.
- Latency, counted in cycles between the producer issuing and the consumer issuing:
  - ALU→use: 1 cycle, no stall; consumer gets fwd = 01.
  - Load→use: 1 bubble (LOAD_LAT = 1); consumer gets fwd = 10.
  - Mul→use: MUL_LAT-1 bubbles.
- All stall/forward outputs are combinational from inputs and registered state. No output is registered.
- Simultaneous redirect and hazard: redirect wins; stall = 0, flush_d = 1, bubble_e = 1.

## Test plan
- Reset, then ALU `add x5` followed by a consumer of x5: stall_fd stays 0; consumer in E sees fwd_a = 01; pend[5] is clear after 1 edge.
- `lw x6` followed by `add x7,x6,x1`: stall_fd = 1 for exactly 1 cycle with bubble_e = 1; next cycle issued = 1, and in E fwd_a = 10.
- MUL_LAT = 4: `mul x8` followed by a consumer of x8: 3 stall cycles, then issue. A second `mul x8` right after the first: WAW stall for 3 cycles.
- `lw x9` in E with redirect_m = 1: pend[9] is cleared; the following `add x10,x9` issues with no stall.
- freeze = 1 for 5 cycles mid-load-stall: cnt values hold and issued = 0; after release, exactly 1 remaining stall cycle.
- Consumer of x0 after any write to x0: stall_fd = 0 and fwd = 00. Assert reset mid-mul: all pend = 0 on the next cycle.
